hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the MIPS core; consumes the per-instruction Tuse/Tnew codes from the D-stage decoder.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_operand_chk.sv | 45 ++++
 rtl/hazard_ctrl.sv | 95 +++++++++
 tb/tb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared hazard encodings: Tuse/Tnew codes and forwarding select codes.
// Decoder tables target these values directly.
package hazard_ctrl_pkg;

  localparam int TW_DEF = 2;
  localparam int FWD_W  = 3;

  localparam logic [TW_DEF-1:0] TNEW_ALU = 2'd1;
  localparam logic [TW_DEF-1:0] TNEW_DM  = 2'd2;
  localparam logic [TW_DEF-1:0] TNEW_PC  = 2'd1;
  localparam logic [TW_DEF-1:0] T_NONE   = 2'd3;

  localparam logic [FWD_W-1:0] FWD_RF = 3'd0;
  localparam logic [FWD_W-1:0] FWD_E  = 3'd1;
  localparam logic [FWD_W-1:0] FWD_M  = 3'd2;
  localparam logic [FWD_W-1:0] FWD_W_ = 3'd3;

endpackage

// File: rtl/hazard_ctrl_operand_chk.sv
// Per-operand check: youngest scoreboard match drives the stall
// term and the forwarding select.
module hazard_operand_chk
  import hazard_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int TW    = 2
) (
  input  logic [AW-1:0]       i_src,
  input  logic [TW-1:0]       i_tuse,
  input  logic [DEPTH-1:0]    i_valid,
  input  logic [DEPTH*AW-1:0] i_addr,
  input  logic [DEPTH*TW-1:0] i_tnew,
  output logic                o_stall,
  output logic [FWD_W-1:0]    o_fwd
);

  logic             w_hit;
  logic             w_used;
  logic [FWD_W-1:0] w_k;
  logic [TW-1:0]    w_tn;

  assign w_used = (i_tuse != '1);

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_hit = 1'b0;
    w_k   = FWD_RF;
    w_tn  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (i_valid[k-1] &&
          i_addr[(k-1)*AW +: AW] == i_src &&
          i_src != '0) begin
        w_hit = 1'b1;
        w_k   = FWD_W'(k);
        w_tn  = i_tnew[(k-1)*TW +: TW];
      end
    end
  end

  assign o_stall = w_used && w_hit && (w_tn > i_tuse);
  assign o_fwd   = (w_used && w_hit && w_tn == '0) ? w_k : FWD_RF;

endmodule

// File: rtl/hazard_ctrl.sv
// MIPS pipeline hazard controller: E..W scoreboard, stall and forwarding.
// Define HAZARD_MD_EN to interlock the multi-cycle mult/div unit.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int N_SRC  = 2,
  parameter int MD_LAT = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC*AW-1:0]    src_addr_d,
  input  logic [N_SRC*TW-1:0]    tuse_d,
  input  logic [AW-1:0]          dst_addr_d,
  input  logic [TW-1:0]          tnew_d,
  input  logic                   md_start_d,
  input  logic                   md_use_d,
  output logic                   stall,
  output logic [N_SRC*FWD_W-1:0] fwd_sel,
  output logic                   md_busy
);

  logic [DEPTH-1:0]    r_valid;
  logic [DEPTH*AW-1:0] r_addr;
  logic [DEPTH*TW-1:0] r_tnew;
  logic [N_SRC-1:0]    w_op_stall;
  logic                w_md_stall;
  logic                w_ins_v;

  for (genvar i = 0; i < N_SRC; i++) begin : g_op
    hazard_operand_chk #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .TW    (TW)
    ) u_chk (
      .i_src   (src_addr_d[i*AW +: AW]),
      .i_tuse  (tuse_d[i*TW +: TW]),
      .i_valid (r_valid),
      .i_addr  (r_addr),
      .i_tnew  (r_tnew),
      .o_stall (w_op_stall[i]),
      .o_fwd   (fwd_sel[i*FWD_W +: FWD_W])
    );
  end

  assign stall   = (|w_op_stall) | w_md_stall;
  assign w_ins_v = !stall && tnew_d != '1 && dst_addr_d != '0;

  // Stall only turns the D insertion into a bubble; older entries advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_addr  <= '0;
      r_tnew  <= '0;
    end else begin
      r_valid[0]       <= w_ins_v;
      r_addr[AW-1:0]   <= stall ? '0 : dst_addr_d;
      r_tnew[TW-1:0]   <= stall ? '0 : tnew_d;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k]         <= r_valid[k-1];
        r_addr[k*AW +: AW] <= r_addr[(k-1)*AW +: AW];
        r_tnew[k*TW +: TW] <= (r_tnew[(k-1)*TW +: TW] == '0) ?
                              '0 : r_tnew[(k-1)*TW +: TW] - 1'b1;
      end
    end
  end

`ifdef HAZARD_MD_EN
  localparam int CW = $clog2(MD_LAT + 1);

  logic [CW-1:0] r_md_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= '0;
    end else if (md_start_d && !stall) begin
      r_md_cnt <= CW'(MD_LAT);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

  assign md_busy    = (r_md_cnt != '0);
  assign w_md_stall = md_use_d && md_busy;
`else
  logic w_unused_md;

  assign w_unused_md = ^{md_start_d, md_use_d, (MD_LAT != 0)};
  assign md_busy     = 1'b0;
  assign w_md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against an issue-history model.
// Honours HAZARD_MD_EN when the design is built with it.
module tb_hazard_ctrl;
  localparam int DEPTH  = 3;
  localparam int AW     = 5;
  localparam int TW     = 2;
  localparam int N_SRC  = 2;
  localparam int MD_LAT = 5;
  localparam int HN     = 64;
`ifdef HAZARD_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_SRC*AW-1:0] src_addr_d = '0;
  logic [N_SRC*TW-1:0] tuse_d = '1;
  logic [AW-1:0]       dst_addr_d = '0;
  logic [TW-1:0]       tnew_d = '1;
  logic                md_start_d = 1'b0;
  logic                md_use_d = 1'b0;
  logic                stall;
  logic [N_SRC*3-1:0]  fwd_sel;
  logic                md_busy;

  hazard_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .TW(TW), .N_SRC(N_SRC), .MD_LAT(MD_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_addr_d (src_addr_d),
    .tuse_d     (tuse_d),
    .dst_addr_d (dst_addr_d),
    .tnew_d     (tnew_d),
    .md_start_d (md_start_d),
    .md_use_d   (md_use_d),
    .stall      (stall),
    .fwd_sel    (fwd_sel),
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue history: slot c holds what D inserted at cycle c.
  // Entry k at cycle n is the insertion of cycle n-k, with
  // its Tnew reduced by k-1 and floored at zero.
  logic           hv [HN];
  logic [AW-1:0]  ha [HN];
  int             ht [HN];
  int             cyc = 100;
  int             md_last = -100;

  logic               e_st;
  logic [N_SRC*3-1:0] e_fw;
  logic               e_busy;

  task automatic model_clear();
    for (int j = 0; j < HN; j++) begin
      hv[j] = 1'b0;
      ha[j] = '0;
      ht[j] = 0;
    end
    md_last = -100;
  endtask

  task automatic model_eval();
    int a, t, idx, rem;
    bit found;
    e_busy = MD_EN && (cyc - md_last) >= 1 && (cyc - md_last) <= MD_LAT;
    e_st   = md_use_d && e_busy;
    e_fw   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      a = int'(src_addr_d[i*AW +: AW]);
      t = int'(tuse_d[i*TW +: TW]);
      found = 1'b0;
      if (t != 3 && a != 0) begin
        for (int k = 1; k <= DEPTH; k++) begin
          idx = (cyc - k) % HN;
          if (!found && hv[idx] && int'(ha[idx]) == a) begin
            found = 1'b1;
            rem = ht[idx] - (k - 1);
            if (rem < 0) rem = 0;
            if (rem > t) e_st = 1'b1;
            if (rem == 0) e_fw[i*3 +: 3] = 3'(k);
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    int idx;
    idx = cyc % HN;
    hv[idx] = !e_st && tnew_d != 2'd3 && dst_addr_d != '0;
    ha[idx] = dst_addr_d;
    ht[idx] = int'(tnew_d);
    if (MD_EN && md_start_d && !e_st) md_last = cyc;
    cyc++;
  endtask

  task automatic step(input string tag, input int rs, input int rt,
                      input int tu_rs, input int tu_rt, input int dst,
                      input int tn, input bit mds, input bit mdu);
    src_addr_d = {AW'(rt), AW'(rs)};
    tuse_d     = {TW'(tu_rt), TW'(tu_rs)};
    dst_addr_d = AW'(dst);
    tnew_d     = TW'(tn);
    md_start_d = mds;
    md_use_d   = mdu;
    model_eval();
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall), 32'(e_st));
    chk({tag, ".fwd"}, 32'(fwd_sel), 32'(e_fw));
    chk({tag, ".busy"}, 32'(md_busy), 32'(e_busy));
    @(posedge clk);
    model_commit();
    #1;
  endtask

  initial begin
    model_clear();
    #3;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.fwd", 32'(fwd_sel), 32'd0);
    chk("rst.busy", 32'(md_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addu $3 then addu $4,$3,$3, then another reader of $3
    step("addu3", 1, 2, 1, 1, 3, 1, 0, 0);
    step("addu4", 3, 3, 1, 1, 4, 1, 0, 0);
    step("use3", 3, 0, 1, 3, 0, 3, 0, 0);

    // lw $5 then beq $5,$0: stalls until Tnew decays
    step("lw5", 1, 0, 1, 3, 5, 2, 0, 0);
    step("beq5a", 5, 0, 0, 0, 0, 3, 0, 0);
    chk("beq5a.st", 32'(e_st), 32'd1);
    step("beq5b", 5, 0, 0, 0, 0, 3, 0, 0);
    chk("beq5b.st", 32'(e_st), 32'd1);
    step("beq5c", 5, 0, 0, 0, 0, 3, 0, 0);
    chk("beq5c.st", 32'(e_st), 32'd0);

    // lw $6 then sw $6 with late rt use
    step("lw6", 1, 0, 1, 3, 6, 2, 0, 0);
    step("sw6", 1, 6, 1, 2, 0, 3, 0, 0);
    step("sw6b", 1, 6, 1, 2, 0, 3, 0, 0);
    step("sw6c", 1, 6, 1, 2, 0, 3, 0, 0);

    // two writers of $7, then a reader; writes to $0
    step("w7a", 1, 2, 1, 1, 7, 0, 0, 0);
    step("w7b", 1, 2, 1, 1, 7, 0, 0, 0);
    step("use7", 7, 7, 1, 1, 0, 3, 0, 0);
    step("w0", 1, 2, 1, 1, 0, 2, 0, 0);
    step("use0", 0, 0, 0, 0, 0, 3, 0, 0);

    // mult then mfhi
    step("mult", 8, 9, 1, 1, 0, 3, 1, 1);
    for (int j = 0; j < MD_LAT + 1; j++)
      step("mfhi", 0, 0, 3, 3, 10, 1, 0, 1);

    // async reset in the middle of a load-use stall
    step("lw5r", 1, 0, 1, 3, 5, 2, 1, 1);
    step("beqr", 5, 0, 0, 0, 0, 3, 0, 0);
    src_addr_d = {AW'(0), AW'(5)};
    tuse_d     = '0;
    md_use_d   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.stall", 32'(stall), 32'd0);
    chk("arst.fwd", 32'(fwd_sel), 32'd0);
    chk("arst.busy", 32'(md_busy), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    step("post_rst", 5, 5, 0, 0, 0, 3, 0, 1);

    for (int n = 0; n < 500; n++) begin
      bit ms;
      ms = ($urandom_range(0, 15) == 0);
      step("rnd",
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           ms, ms | ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
